// File: rtl/calc1_pkg.sv
// Shared command/response encodings, widths and the per-port capture state for calc1.
package calc1_pkg;

  localparam int DATA_W = 32;
  localparam int CMD_W  = 4;
  localparam int RSP_W  = 2;
  localparam int NPORT  = 4;
  localparam int SHAMT_W = 5;

  localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_LSH = 4'd5;
  localparam logic [CMD_W-1:0] CMD_RSH = 4'd6;

  localparam logic [RSP_W-1:0] RSP_NONE = 2'd0;
  localparam logic [RSP_W-1:0] RSP_SUCC = 2'd1;
  localparam logic [RSP_W-1:0] RSP_INOF = 2'd2;
  localparam logic [RSP_W-1:0] RSP_IERR = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    OP2,
    PEND
  } state_t;

  function automatic logic is_alu_cmd(input logic [CMD_W-1:0] c);
    return (c == CMD_ADD) || (c == CMD_SUB);
  endfunction

  function automatic logic is_shf_cmd(input logic [CMD_W-1:0] c);
    return (c == CMD_LSH) || (c == CMD_RSH);
  endfunction

endpackage

// File: rtl/calc1_port.sv
// One calc1 port: captures command and two operands, requests a unit, registers the response.
module calc1_port
  import calc1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [0:3]        cmd_in,
  input  logic [0:31]       data_in,
  input  logic              gnt_alu,
  input  logic              gnt_shf,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [RSP_W-1:0]  alu_resp,
  input  logic [DATA_W-1:0] shf_data,
  output logic              req_alu,
  output logic              req_shf,
  output logic [CMD_W-1:0]  cmd_p0,
  output logic [DATA_W-1:0] op1_p0,
  output logic [DATA_W-1:0] op2_p1,
  output logic [0:31]       out_data,
  output logic [0:1]        out_resp
);

  state_t state;

  assign req_alu = (state == PEND) && is_alu_cmd(cmd_p0);
  assign req_shf = (state == PEND) && is_shf_cmd(cmd_p0);

  // Control and output register; the response lives for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      out_data <= '0;
      out_resp <= RSP_NONE;
    end else begin
      out_data <= '0;
      out_resp <= RSP_NONE;
      case (state)
        IDLE: if (cmd_in != CMD_NOP) state <= OP2;
        OP2:  state <= PEND;
        PEND: begin
          if (gnt_alu) begin
            out_data <= alu_data;
            out_resp <= alu_resp;
            state    <= IDLE;
          end else if (gnt_shf) begin
            out_data <= shf_data;
            out_resp <= RSP_SUCC;
            state    <= IDLE;
          end else if (!req_alu && !req_shf) begin
            // Unknown opcode: no unit will ever grant it, so answer at once.
            out_resp <= RSP_INOF;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture: p0 = command edge, p1 = second-operand edge.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      cmd_p0 <= cmd_in;
      op1_p0 <= data_in;
    end
    if (state == OP2) op2_p1 <= data_in;
  end

endmodule

// File: rtl/calc1_ref_model.sv
// calc1 top: four ports sharing one add/sub unit and one shift unit under fixed priority.
module calc1_ref_model
  import calc1_pkg::*;
(
  input  logic        c_clk,
  input  logic [1:7]  reset,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req4_data_in,
  output logic [0:31] out_data1,
  output logic [0:1]  out_resp1,
  output logic [0:31] out_data2,
  output logic [0:1]  out_resp2,
  output logic [0:31] out_data3,
  output logic [0:1]  out_resp3,
  output logic [0:31] out_data4,
  output logic [0:1]  out_resp4
);

  function automatic logic [RSP_W+DATA_W-1:0] alu_eval(input logic [CMD_W-1:0] c,
                                                      input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    if (c == CMD_SUB) begin
      if (b > a) return {RSP_INOF, {DATA_W{1'b0}}};
      return {RSP_SUCC, a - b};
    end
    sum = {1'b0, a} + {1'b0, b};
    if (sum[DATA_W]) return {RSP_INOF, {DATA_W{1'b0}}};
    return {RSP_SUCC, sum[DATA_W-1:0]};
  endfunction

  function automatic logic [DATA_W-1:0] shf_eval(input logic [CMD_W-1:0] c,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [SHAMT_W-1:0] amt);
    return (c == CMD_LSH) ? (a << amt) : (a >> amt);
  endfunction

  logic                rst;
  logic [CMD_W-1:0]    cmd_in_a  [NPORT];
  logic [DATA_W-1:0]   data_in_a [NPORT];
  logic [DATA_W-1:0]   out_data_a[NPORT];
  logic [RSP_W-1:0]    out_resp_a[NPORT];
  logic [CMD_W-1:0]    cmd_a     [NPORT];
  logic [DATA_W-1:0]   op1_a     [NPORT];
  logic [DATA_W-1:0]   op2_a     [NPORT];
  logic [NPORT-1:0]    req_alu, req_shf, gnt_alu, gnt_shf;
  logic [CMD_W-1:0]    alu_cmd, shf_cmd;
  logic [DATA_W-1:0]   alu_a, alu_b, shf_a, alu_data, shf_data;
  logic [SHAMT_W-1:0]  shf_amt;
  logic [RSP_W-1:0]    alu_resp;

  assign rst = |reset;

  assign cmd_in_a[0] = req1_cmd_in;  assign data_in_a[0] = req1_data_in;
  assign cmd_in_a[1] = req2_cmd_in;  assign data_in_a[1] = req2_data_in;
  assign cmd_in_a[2] = req3_cmd_in;  assign data_in_a[2] = req3_data_in;
  assign cmd_in_a[3] = req4_cmd_in;  assign data_in_a[3] = req4_data_in;

  assign out_data1 = out_data_a[0];  assign out_resp1 = out_resp_a[0];
  assign out_data2 = out_data_a[1];  assign out_resp2 = out_resp_a[1];
  assign out_data3 = out_data_a[2];  assign out_resp3 = out_resp_a[2];
  assign out_data4 = out_data_a[3];  assign out_resp4 = out_resp_a[3];

  // Lowest-index requester wins: isolate the least significant set bit.
  assign gnt_alu = req_alu & (~req_alu + 4'd1);
  assign gnt_shf = req_shf & (~req_shf + 4'd1);

  always_comb begin
    alu_cmd = CMD_NOP;
    alu_a   = '0;
    alu_b   = '0;
    shf_cmd = CMD_NOP;
    shf_a   = '0;
    shf_amt = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (gnt_alu[i]) begin
        alu_cmd = cmd_a[i];
        alu_a   = op1_a[i];
        alu_b   = op2_a[i];
      end
      if (gnt_shf[i]) begin
        shf_cmd = cmd_a[i];
        shf_a   = op1_a[i];
        shf_amt = op2_a[i][SHAMT_W-1:0];
      end
    end
  end

  assign {alu_resp, alu_data} = alu_eval(alu_cmd, alu_a, alu_b);
  assign shf_data             = shf_eval(shf_cmd, shf_a, shf_amt);

  for (genvar i = 0; i < NPORT; i++) begin : g_port
    calc1_port u_port (
      .clk      (c_clk),
      .rst      (rst),
      .cmd_in   (cmd_in_a[i]),
      .data_in  (data_in_a[i]),
      .gnt_alu  (gnt_alu[i]),
      .gnt_shf  (gnt_shf[i]),
      .alu_data (alu_data),
      .alu_resp (alu_resp),
      .shf_data (shf_data),
      .req_alu  (req_alu[i]),
      .req_shf  (req_shf[i]),
      .cmd_p0   (cmd_a[i]),
      .op1_p0   (op1_a[i]),
      .op2_p1   (op2_a[i]),
      .out_data (out_data_a[i]),
      .out_resp (out_resp_a[i])
    );
  end

endmodule

// File: tb/tb_calc1_ref_model.sv
// Scoreboard bench for calc1_ref_model: transaction-level reference model feeds per-port queues.
module tb_calc1_ref_model;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0]  reset;
  logic [3:0]  cmd  [4];
  logic [31:0] data [4];
  logic [31:0] od   [4];
  logic [1:0]  orr  [4];

  calc1_ref_model dut (
    .c_clk(clk), .reset(reset),
    .req1_cmd_in(cmd[0]), .req1_data_in(data[0]),
    .req2_cmd_in(cmd[1]), .req2_data_in(data[1]),
    .req3_cmd_in(cmd[2]), .req3_data_in(data[2]),
    .req4_cmd_in(cmd[3]), .req4_data_in(data[3]),
    .out_data1(od[0]), .out_resp1(orr[0]),
    .out_data2(od[1]), .out_resp2(orr[1]),
    .out_data3(od[2]), .out_resp3(orr[2]),
    .out_data4(od[3]), .out_resp4(orr[3])
  );

  typedef struct {
    int          cyc;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t sb [4][$];

  // Reference model: where each port is in its command lifecycle.
  int          phase [4];   // 0 free, 1 waiting for operand2, 2 waiting for a unit
  logic [3:0]  mcmd  [4];
  logic [31:0] mop1  [4];
  logic [31:0] mop2  [4];

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input int p, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s port%0d cyc %0d: got %0h, required %0h", name, p + 1, cyc, act, req);
    end
  endtask

  function automatic void ref_result(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                     output logic [1:0] r, output logic [31:0] d);
    longint unsigned aa = a;
    longint unsigned bb = b;
    longint unsigned sh = b % 32;
    r = 2'd1;
    d = 32'd0;
    case (c)
      4'd1: if (aa + bb > 64'hFFFF_FFFF) r = 2'd2; else d = 32'(aa + bb);
      4'd2: if (bb > aa) r = 2'd2; else d = 32'(aa - bb);
      4'd5: d = 32'((aa * (64'd1 << sh)) % 64'h1_0000_0000);
      default: d = 32'(aa / (64'd1 << sh));
    endcase
  endfunction

  function automatic bit is_valid_cmd(input logic [3:0] c);
    return c == 4'd1 || c == 4'd2 || c == 4'd5 || c == 4'd6;
  endfunction

  // Predict what the coming edge registers, then take the edge.
  task automatic step();
    int aw, sw;
    exp_t e;
    if (reset != 0) begin
      for (int p = 0; p < 4; p++) phase[p] = 0;
    end else begin
      aw = -1;
      sw = -1;
      for (int p = 0; p < 4; p++)
        if (phase[p] == 2) begin
          if ((mcmd[p] == 4'd1 || mcmd[p] == 4'd2) && aw < 0) aw = p;
          if ((mcmd[p] == 4'd5 || mcmd[p] == 4'd6) && sw < 0) sw = p;
        end
      for (int p = 0; p < 4; p++) begin
        if (phase[p] == 2) begin
          if (!is_valid_cmd(mcmd[p])) begin
            e.cyc = cyc + 1; e.resp = 2'd2; e.data = 32'd0;
            sb[p].push_back(e);
            phase[p] = 0;
          end else if (p == aw || p == sw) begin
            e.cyc = cyc + 1;
            ref_result(mcmd[p], mop1[p], mop2[p], e.resp, e.data);
            sb[p].push_back(e);
            phase[p] = 0;
          end
        end else if (phase[p] == 1) begin
          mop2[p]  = data[p];
          phase[p] = 2;
        end else if (cmd[p] != 4'd0) begin
          mcmd[p]  = cmd[p];
          mop1[p]  = data[p];
          phase[p] = 1;
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      for (int p = 0; p < 4; p++) begin
        cmd[p]  = 4'd0;
        data[p] = $urandom;
      end
      step();
    end
  endtask

  // Issue up to two commands in the same cycle (pb < 0 means only one).
  task automatic pair(input int pa, input logic [3:0] ca, input logic [31:0] a1, input logic [31:0] a2,
                      input int pb, input logic [3:0] cb, input logic [31:0] b1, input logic [31:0] b2);
    cmd[pa] = ca; data[pa] = a1;
    if (pb >= 0) begin cmd[pb] = cb; data[pb] = b1; end
    step();
    cmd[pa] = 4'd0; data[pa] = a2;
    if (pb >= 0) begin cmd[pb] = 4'd0; data[pb] = b2; end
    step();
  endtask

  // Monitor: pops an expectation whenever a port presents a response.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int p = 0; p < 4; p++) begin
        if (orr[p] != 2'd0) begin
          if (sb[p].size() == 0) begin
            chk("unexpected_resp", p, {30'd0, orr[p]}, 32'd0);
          end else begin
            chk("resp_cycle", p, sb[p][0].cyc, cyc);
            chk("resp_code", p, {30'd0, orr[p]}, {30'd0, sb[p][0].resp});
            chk("resp_data", p, od[p], sb[p][0].data);
            void'(sb[p].pop_front());
          end
        end else begin
          chk("idle_data", p, od[p], 32'd0);
          if (sb[p].size() != 0 && sb[p][0].cyc <= cyc) begin
            chk("missing_resp", p, 32'd0, {30'd0, sb[p][0].resp});
            void'(sb[p].pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] ctab [12];
    ctab = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd4, 4'd7, 4'd15};
    reset = 7'h7F;
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd0; data[p] = 32'd0; phase[p] = 0;
    end
    step();
    mon_en = 1'b1;
    for (int p = 0; p < 4; p++) begin
      chk("reset_resp", p, {30'd0, orr[p]}, 32'd0);
      chk("reset_data", p, od[p], 32'd0);
    end
    step();
    reset = 7'd0;
    quiet(2);

    pair(0, 4'd1, 32'd255, 32'd255, -1, 4'd0, 32'd0, 32'd0);
    quiet(3);
    pair(1, 4'd2, 32'd1, 32'd100, -1, 4'd0, 32'd0, 32'd0);
    quiet(3);
    pair(1, 4'd2, 32'd100, 32'd1, -1, 4'd0, 32'd0, 32'd0);
    quiet(3);
    pair(2, 4'd1, 32'd1, 32'd4, 3, 4'd1, 32'd2, 32'd8);
    quiet(4);
    pair(0, 4'd1, 32'd7, 32'd9, 1, 4'd5, 32'd1, 32'd31);
    quiet(3);
    pair(2, 4'd1, 32'hFFFF_FFFF, 32'd1, 3, 4'd3, 32'd5, 32'd6);
    quiet(3);
    pair(1, 4'd6, 32'h8000_0000, 32'd36, -1, 4'd0, 32'd0, 32'd0);
    quiet(3);

    cmd[0] = 4'd1; data[0] = 32'd7;
    step();
    cmd[0] = 4'd0; data[0] = 32'd9; reset = 7'b0001000;
    step();
    reset = 7'd0;
    quiet(5);
    pair(0, 4'd1, 32'd2, 32'd3, -1, 4'd0, 32'd0, 32'd0);
    quiet(3);

    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 4; p++) begin
        cmd[p] = ($urandom_range(0, 2) == 0) ? ctab[$urandom_range(0, 11)] : 4'd0;
        case ($urandom_range(0, 3))
          0: data[p] = $urandom_range(0, 40);
          1: data[p] = 32'hFFFF_FFFF - $urandom_range(0, 40);
          default: data[p] = $urandom;
        endcase
      end
      reset = ($urandom_range(0, 199) == 0) ? 7'(1 << $urandom_range(0, 6)) : 7'd0;
      step();
    end
    reset = 7'd0;
    quiet(10);

    for (int p = 0; p < 4; p++) chk("queue_drained", p, sb[p].size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc1_ref_model.md
# calc1_ref_model

Four-port 32-bit integer calculator; behavioural golden model of the calc1 block, run in lock-step with the DUV so their outputs compare cycle-by-cycle. Each port independently issues add, subtract, shift-left and shift-right commands. Requests contend for one add/sub unit and one shift unit. Each command gets exactly one single-cycle response on its own port.

## Interface
No parameters.
- c_clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  [1:7]  synchronous, active-high.
  - Block is in reset at any rising edge where any bit is 1.
- reqN_cmd_in (N=1..4)  in  [0:3]  command: 0 NOP, 1 ADD, 2 SUB, 5 LSH, 6 RSH; all other codes invalid.
- reqN_data_in (N=1..4)  in  [0:31]  operand bus.
  - Carries operand1 in the command cycle and operand2 in the next cycle.
  - Bit 31 is the LSB.
- out_dataN (N=1..4)  out  [0:31]  result; 0 when no response.
- out_respN (N=1..4)  out  [0:1]  response code:
  - 0 none
  - 1 success
  - 2 overflow/underflow/invalid command
  - 3 internal error; never generated.

## Operation
- Per-port FSM states:
  - IDLE: a non-zero cmd at an edge captures cmd and operand1, then go to OP2.
  - OP2: the next edge captures operand2 from data_in; cmd_in is ignored. Go to PEND.
  - PEND: wait for a grant, then drive the response and return to IDLE.
- A port in OP2 or PEND ignores its cmd input; commands issued while busy are dropped.
- Arbitration: add/sub unit (ADD, SUB) and shift unit (LSH, RSH).
  - Each unit grants one PEND port per cycle, fixed priority port1 > port2 > port3 > port4.
  - Both units can grant in the same cycle.
- Invalid commands need no unit and are answered from PEND immediately with resp 2, data 0.
- Arithmetic (unsigned, 32-bit):
  - ADD: op1+op2. A carry out gives resp 2, data 0.
  - SUB: op1−op2. op2>op1 gives resp 2, data 0.
  - LSH: op1 << op2[27:31], zero fill, resp 1. Bits shifted out are lost; this is not overflow.
  - RSH: op1 >> op2[27:31], logical, resp 1.
  - Only the low 5 bits of op2 are used for shift amounts.
- Reset:
  - All ports return to IDLE and any pending command is discarded.
  - out_data and out_resp are 0 on all ports from the first reset edge onward.

## Timing
- E0 = edge sampling cmd+op1, E1 = edge sampling op2, E2 = first arbitration edge.
- If the port wins at edge Ek (k≥2), its response is registered at Ek and is visible from Ek until Ek+1.
  - Minimum latency: response valid after E2.
  - Each losing cycle adds one cycle.
- The response is held exactly one cycle. out_resp/out_data return to 0 at the next edge unless a new response for that port is registered there.
- A port may issue its next command in the cycle its response is visible: E0 may equal the grant edge + 1.
- Reset asserted mid-operation, including in OP2 or PEND, aborts the operation with no response. Reset takes priority over every other event.
- The bench drives cmd = 0 before and after commands. X on cmd is not a supported input.

## Structure
- Package calc1_pkg holds:
  - CMD_NOP/ADD/SUB/LSH/RSH constants (0,1,2,5,6)
  - RSP_NONE/SUCC/INOF/IERR constants (0..3)
  - state enum IDLE/OP2/PEND
- Sub-module calc1_port, instantiated 4×, contains:
  - capture FSM
  - cmd/op1/op2 registers
  - request outputs to the units
  - grant inputs
  - output register
- Top level contains the two priority arbiters, the add/sub datapath and the shift datapath.

## Test plan
- Port1: ADD, data 255 in both cycles → out_resp1=1, out_data1=510 after E2, 0 the cycle after.
- Port2: SUB with op1=1, op2=100 → out_resp2=2, out_data2=0 (underflow). SUB 100−1 → resp 1, data 99.
- Ports 3 and 4 issue ADD in the same cycle (3: 1+4, 4: 2+8):
  - out_resp3=1, data 5 after E2.
  - out_resp4=1, data 10 one cycle later.
- Port1 ADD and port2 LSH in the same cycle (op1=1, op2=31) → both respond after E2: port1 per its ADD, port2 data 0x80000000.
- Port3 ADD 0xFFFFFFFF+1 → resp 2, data 0. Port4 cmd 3 → resp 2, data 0 after E2.
- Reset asserted in the OP2 cycle of a port1 ADD → no response ever appears. A new ADD 2+3 after reset → resp 1, data 5.
